// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master / one-slave arbiter. Serialises the instruction
//               fetch port (A) and the load/store port (B) onto the single
//               ram txe/txs handshake. Round-robin on ties, registered
//               outputs, and at least one idle ram_txe cycle between
//               consecutive transactions.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               a_* / b_*          - master request (txe, re, we, addr, wd)
//                                    and response (txs pulse, out data)
//               ram_*              - slave request (txe, re, we, addr, wd)
//                                    and response (txs, out data)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master A (instruction fetch)
  input  logic              a_txe,
  input  logic              a_re,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wd,
  output logic              a_txs,
  output logic [DATA_W-1:0] a_out,
  // master B (load/store)
  input  logic              b_txe,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wd,
  output logic              b_txs,
  output logic [DATA_W-1:0] b_out,
  // ram slave
  output logic              ram_txe,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  input  logic              ram_txs,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_A = 2'd1;
  localparam logic [1:0] S_BUSY_B = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic M_A = 1'b0;
  localparam logic M_B = 1'b1;

  logic [1:0]        state_q,    state_d;
  // last granted master; while BUSY/DRAIN it is also the current owner
  logic              last_q,     last_d;
  logic              ram_txe_q,  ram_txe_d;
  logic              ram_re_q,   ram_re_d;
  logic              ram_we_q,   ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wd_q,   ram_wd_d;
  logic              a_txs_q,    a_txs_d;
  logic              b_txs_q,    b_txs_d;
  logic [DATA_W-1:0] a_out_q,    a_out_d;
  logic [DATA_W-1:0] b_out_q,    b_out_d;

  logic w_grant_a;
  logic w_grant_b;
  logic w_owner_txe;

  // A wins unless B is also requesting and A was the last one served.
  assign w_grant_a   = a_txe && (!b_txe || (last_q == M_B));
  assign w_grant_b   = b_txe && !w_grant_a;
  assign w_owner_txe = (last_q == M_A) ? a_txe : b_txe;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ram_txe_d  = ram_txe_q;
    ram_re_d   = ram_re_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_wd_d   = ram_wd_q;
    a_out_d    = a_out_q;
    b_out_d    = b_out_q;
    a_txs_d    = 1'b0;
    b_txs_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_grant_a) begin
          ram_txe_d  = 1'b1;
          ram_we_d   = a_we;
          ram_re_d   = a_re & ~a_we;   // write takes precedence over read
          ram_addr_d = a_addr;
          ram_wd_d   = a_wd;
          last_d     = M_A;
          state_d    = S_BUSY_A;
        end else if (w_grant_b) begin
          ram_txe_d  = 1'b1;
          ram_we_d   = b_we;
          ram_re_d   = b_re & ~b_we;
          ram_addr_d = b_addr;
          ram_wd_d   = b_wd;
          last_d     = M_B;
          state_d    = S_BUSY_B;
        end
      end

      S_BUSY_A: begin
        if (ram_txs) begin
          if (ram_re_q) begin
            a_out_d = ram_out;
          end
          a_txs_d   = 1'b1;
          ram_txe_d = 1'b0;
          ram_re_d  = 1'b0;
          ram_we_d  = 1'b0;
          state_d   = S_DRAIN;
        end
      end

      S_BUSY_B: begin
        if (ram_txs) begin
          if (ram_re_q) begin
            b_out_d = ram_out;
          end
          b_txs_d   = 1'b1;
          ram_txe_d = 1'b0;
          ram_re_d  = 1'b0;
          ram_we_d  = 1'b0;
          state_d   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // wait for the served master to withdraw its request so that the
        // still-high txe is not mistaken for a new transaction
        if (!w_owner_txe) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= M_B;
      ram_txe_q  <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_wd_q   <= '0;
      a_txs_q    <= 1'b0;
      b_txs_q    <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ram_txe_q  <= ram_txe_d;
      ram_re_q   <= ram_re_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wd_q   <= ram_wd_d;
      a_txs_q    <= a_txs_d;
      b_txs_q    <= b_txs_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
    end
  end

  assign a_txs    = a_txs_q;
  assign b_txs    = b_txs_q;
  assign a_out    = a_out_q;
  assign b_out    = b_out_q;
  assign ram_txe  = ram_txe_q;
  assign ram_re   = ram_re_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_wd   = ram_wd_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter between the cpu's instruction-fetch port (A) and load/store port (B) and the single `ram` port. It serialises requests from both masters onto the ram `txe`/`txs` handshake. It latches each granted request and returns read data and completion to the requesting master only. It resolves simultaneous requests round-robin and guarantees an idle cycle on `ram_txe` between consecutive transactions.

## Interface
Parameters:
- `ADDR_W`, 64, address width (matches `ram_addr`)
- `DATA_W`, 32, data width (matches `ram_out` / `ram_wd`)

Ports. One clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: synchronous active-high reset
- `a_txe` in 1: master A requests a transaction; held until A sees `a_txs`
- `a_re`, `a_we` in 1: A read / write strobe, valid while `a_txe` is high
- `a_addr` in ADDR_W: A address
- `a_wd` in DATA_W: A write data
- `a_txs` out 1: one-cycle completion pulse to A
- `a_out` out DATA_W: A read data, registered, valid from the `a_txs` cycle and held until A's next read completes
- `b_txe`, `b_re`, `b_we`, `b_addr`, `b_wd`, `b_txs`, `b_out`: identical set for master B
- `ram_txe` out 1: transaction enable to ram
- `ram_re`, `ram_we` out 1: read / write strobes to ram
- `ram_addr` out ADDR_W; `ram_wd` out DATA_W: to ram
- `ram_txs` in 1: ram completion, high for at least one cycle
- `ram_out` in DATA_W: ram read data, valid while `ram_txs` is high

## Operation
- **States:** IDLE, BUSY_A, BUSY_B, DRAIN. The register `last` records the last granted master.
- **IDLE**
  - If only one master's `txe` is high, grant it.
  - If both are high, grant the master that is not `last`.
  - On grant, latch that master's addr, wd, re and we into the `ram_*` output registers, set `last`, and go to BUSY_x.
- **Strobe rule:** if both `re` and `we` are high, `we` wins and `ram_re` is forced to 0.
- **BUSY_x**
  - Hold `ram_txe`=1 with the latched request.
  - While in BUSY_x, changes on the master's inputs are ignored.
  - When `ram_txs` is sampled high: register `ram_out` into `x_out` (only if the latched request was a read), pulse `x_txs` for one cycle, drop `ram_txe`, `ram_re` and `ram_we`, and go to DRAIN.
- **DRAIN**
  - `ram_txe`=0.
  - Stay in DRAIN while the granted master's `txe` is still high; it must drop `txe` after seeing `txs`.
  - Once that `txe` is low, return to IDLE. The minimum DRAIN time is 1 cycle.
  - The other master's request stays pending and is granted from IDLE.
- **Write-only transaction:** `x_out` is unchanged.
- **No request:** a `txe` of 0 with neither strobe set is no request. A `txe` of 1 with neither strobe set is still forwarded; ram completes it.

## Timing
- **Reset values:** all `ram_*` outputs 0; `a_txs`, `b_txs`, `a_out`, `b_out` 0; state IDLE; `last`=B, so A wins the first tie.
- **Reset mid-transaction:** `ram_txe` is 0 on the cycle after the reset edge. The in-flight request is abandoned and no `txs` is issued. Masters must re-request.
- **Grant latency:** `txe` sampled high in IDLE at edge N gives `ram_txe`=1 from edge N+1.
- **Completion:** `ram_txs` sampled high at edge M gives `x_txs`=1 and a valid `x_out` during cycle M+1 only. In that same cycle `ram_txe`=0.
- **Throughput:** minimum 4 cycles from grant to the next grant with zero-wait ram: grant, ram completes, DRAIN, IDLE re-grant.
- **Simultaneous request:** a request arriving in the same cycle the other master completes waits for the DRAIN to IDLE transition.
- **Fairness:** under continuous requests from both masters, grants alternate A, B, A, B…
- **Back-to-back:** `ram_txe` never stays high across two transactions; at least one low cycle separates them.

## Test plan
- **Single read A:** reset; `a_txe`=1, `a_re`=1, `a_addr`=0x10; ram returns 0xDEADBEEF → `ram_addr`=0x10 and `ram_re`=1 one cycle after the request; `a_txs` pulses once; `a_out`=0xDEADBEEF; `b_txs` never pulses.
- **Tie:** after reset, A and B both request at once → A is served first, then B. Repeated ties alternate B, A.
- **Write B:** `b_we`=1, `b_addr`=0x20, `b_wd`=0x12345678 → ram stores 0x12345678 at 0x20; `b_out` is unchanged; `b_txs` pulses exactly once.
- **Mid-transaction request:** A is in BUSY and B raises `b_txe` → B is granted only after A's DRAIN; `ram_txe` is low for at least 1 cycle between the two transactions.
- **Reset mid-transaction:** assert `rst` while in BUSY_A → next cycle all outputs are 0 and state is IDLE; no `a_txs` is issued; a re-issued read completes normally.
- **Both strobes:** `a_re`=`a_we`=1 → `ram_we`=1 and `ram_re`=0.
